game_round_ctrl: RTL and testbench
==================================

# game_round_ctrl

Round sequencer for the three-button reaction game. Selects which of three lights is lit, times each round against a slow tick strobe, judges debounced button presses, and owns the 6-bit score and miss count. The score output drives the score display decoder directly. Sits between the debouncers and clock divider on the input side, and the light and score display on the output side.

## Interface
- `SHOW_TICKS`, default 8: ticks a light stays lit before the round counts as a miss (≥2).
- `GAP_TICKS`, default 2: dark ticks between rounds (≥1).
- `MAX_MISSES`, default 3: misses that end the game (1..3).
- `LFSR_SEED`, default 8'hA5: reset value of the light-select LFSR (nonzero).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk` enable pulse from the slow divider; all round timing counts these pulses.
- `start`  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- `btn`  in  3  debounced, active-high, one-cycle press pulses; bit i corresponds to light i.
- `light`  out  3  one-hot in SHOW, 3'b111 in OVER, else 0.
- `score`  out  6  current score, saturating at 63.
- `score_inc`  out  1  one-cycle pulse on each counted hit.
- `misses`  out  2  misses in the current game.
- `game_over`  out  1  high while in OVER.

## Operation
- States: IDLE, GAP, SHOW, OVER.
- Reset forces IDLE, all outputs 0, tick counter 0, LFSR = `LFSR_SEED`. Reset mid-game discards the game.
- IDLE: `btn` ignored. `start` clears `score` and `misses`, then moves to GAP.
- GAP: lights off, `btn` ignored.
  - After `GAP_TICKS` ticks, latch index = `lfsr[1:0]`. If that value is 3, index = (previous index + 1) mod 3.
  - Move to SHOW.
- SHOW: `light` = one-hot(index).
  - Hit: press with `btn` == `light` exactly. `score` +1, saturating at 63. `score_inc` pulses; `score` still saturates at 63 but `score_inc` pulses anyway. Next state GAP.
  - Wrong: any `btn` bit set outside the lit bit. This includes the lit bit pressed together with another bit.
  - Timeout: window expires with no press.
  - Wrong or timeout: `misses` +1. Next state OVER if new `misses` == `MAX_MISSES`, else GAP.
  - Press and timeout in the same cycle: the press is judged and the timeout is ignored.
- OVER: `light` = 3'b111, `game_over` = 1, `score` and `misses` held. `start` restarts exactly as from IDLE.
- `start` in GAP or SHOW is ignored.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every `clk`, independent of state, so light choice depends on player timing.

## Timing
- All outputs are registered.
- `light`, `game_over`, `score`, `misses` and `score_inc` change on the `clk` edge that samples the causing input. They are visible the following cycle.
- Tick counter clears on every state entry and increments on each `tick` cycle.
- A phase exits on the `tick` cycle where the count reaches the limit. Window length therefore varies by up to 1 tick (e.g. 7–8 ticks for `SHOW_TICKS`=8).
- A press and a `tick` in the same cycle: the press wins.
- Minimum round: 1 cycle after SHOW entry, a hit is accepted.

## Configuration
- `GAME_SPEEDUP_EN` defined: SHOW window = `SHOW_TICKS` − floor(`score`/8), with a floor of 2 ticks.
- Undefined: window fixed at `SHOW_TICKS`, and the divider logic is absent.

## Structure
- Shared package `game_pkg`:
  - state enum (`IDLE`, `GAP`, `SHOW`, `OVER`)
  - LFSR tap mask
  - score width (6) and saturation constant (63)
  - speed-up step (8) and minimum window (2)
- One sub-module `light_lfsr`: 8-bit LFSR with seed parameter. Outputs the current value and advances every clock.
- FSM, tick counter, judging and score/miss registers stay in `game_round_ctrl`.

## Test plan
- Reset held low, then released → `light`=0, `score`=0, `misses`=0, `game_over`=0, state IDLE. `btn` pulses cause no change.
- `start`, wait for SHOW, then press the matching `btn` → one `score_inc` pulse, `score`=1, `light`=0 the next cycle, new light after 2 ticks.
- With `MAX_MISSES`=3: three timeouts (8 ticks each, no press) → `misses` 1, 2, 3. `game_over`=1 and `light`=3'b111 after the third; `score` held.
- In SHOW with lit bit 0, press `btn`=3'b011 → counts as a miss, `score` unchanged. In a separate SHOW, press `btn`=lit bit on the timeout tick → counts as a hit.
- Force `score`=63 via 63 hits, then one more hit → `score` stays 63, `score_inc` still pulses.
- With `GAME_SPEEDUP_EN`, `score`=16: SHOW window = 6 ticks. At `score`=48 the window is 2 ticks, and it never drops below 2.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

    localparam int                SCORE_W   = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    localparam int SPEEDUP_STEP = 8;
    localparam int MIN_WINDOW   = 2;

    localparam int TICK_CNT_W = 8;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player/display-side signal bundle of the round sequencer.
// master: the surrounding logic (debouncers, divider, displays).
// slave : game_round_ctrl itself.
interface game_round_ctrl_if;
    import game_pkg::*;

    logic               tick;
    logic               start;
    logic [2:0]         btn;
    logic [2:0]         light;
    logic [SCORE_W-1:0] score;
    logic               score_inc;
    logic [1:0]         misses;
    logic               game_over;

    modport master (
        output tick, start, btn,
        input  light, score, score_inc, misses, game_over
    );

    modport slave (
        input  tick, start, btn,
        output light, score, score_inc, misses, game_over
    );

endinterface

// File: rtl/light_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next light.
module light_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAP_MASK);

    // Shift every clock, regardless of game state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= SEED;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the three-button reaction game.
// Optional build macro: GAME_SPEEDUP_EN shortens the SHOW window as the
// score grows (one tick per 8 points, never below 2 ticks).
//
// state | meaning
// IDLE  | after reset, waiting for start; buttons ignored
// GAP   | lights dark between rounds; buttons ignored
// SHOW  | one light lit, waiting for a press or the window to expire
// OVER  | miss limit reached; all lights on, score/misses frozen
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int         SHOW_TICKS = 8,
    parameter int         GAP_TICKS  = 2,
    parameter int         MAX_MISSES = 3,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    game_round_ctrl_if.slave   gif
);

    localparam logic [TICK_CNT_W-1:0] SHOW_LIM = TICK_CNT_W'(SHOW_TICKS);
    localparam logic [TICK_CNT_W-1:0] GAP_LIM  = TICK_CNT_W'(GAP_TICKS);
    localparam logic [TICK_CNT_W-1:0] CNT_ONE  = TICK_CNT_W'(1);
    localparam logic [1:0]            MISS_LIM = 2'(MAX_MISSES);

    state_t                 state_q, state_d;
    logic [TICK_CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [1:0]             misses_q, misses_d;
    logic [1:0]             miss_next;
    logic                   inc_q, inc_d;
    logic [2:0]             light_q, light_d;
    logic                   over_q, over_d;
    logic [TICK_CNT_W-1:0]  show_limit;
    logic [TICK_CNT_W-1:0]  phase_limit;
    logic                   phase_done;
    logic [2:0]             lit;
    logic [7:0]             lfsr_val;
    logic [1:0]             lfsr_sel;
    logic                   lfsr_unused;

    light_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_val)
    );

    // Only the two low bits pick the light; the rest just keep the sequence long
    assign lfsr_sel    = lfsr_val[1:0];
    assign lfsr_unused = ^lfsr_val[7:2];

`ifdef GAME_SPEEDUP_EN
    localparam int                    SPEED_SHIFT = $clog2(SPEEDUP_STEP);
    localparam logic [TICK_CNT_W-1:0] MIN_WIN     = TICK_CNT_W'(MIN_WINDOW);

    logic [TICK_CNT_W-1:0] speed_cut;

    // Window shrinks one tick per speed-up step of score, clamped at the minimum
    always_comb begin
        speed_cut = TICK_CNT_W'(score_q >> SPEED_SHIFT);
        if (SHOW_LIM >= speed_cut + MIN_WIN) begin
            show_limit = SHOW_LIM - speed_cut;
        end else begin
            show_limit = MIN_WIN;
        end
    end
`else
    assign show_limit = SHOW_LIM;
`endif

    assign lit         = idx_to_onehot(idx_q);
    assign miss_next   = misses_q + 2'd1;
    assign phase_limit = (state_q == SHOW) ? show_limit : GAP_LIM;
    assign phase_done  = gif.tick && ((cnt_q + CNT_ONE) == phase_limit);

    // Next state, round judging, score/miss update and registered output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        score_d  = score_q;
        misses_d = misses_q;
        inc_d    = 1'b0;
        light_d  = 3'b000;
        over_d   = 1'b0;

        if (gif.tick && (state_q == GAP || state_q == SHOW)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE, OVER: begin
                if (gif.start) begin
                    score_d  = '0;
                    misses_d = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (phase_done) begin
                    // Value 3 has no light; step past the previous one instead
                    if (lfsr_sel == 2'd3) begin
                        idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        idx_d = lfsr_sel;
                    end
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // A press in the same cycle as the last tick is judged, not timed out
                if (|gif.btn) begin
                    if (gif.btn == lit) begin
                        score_d = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                        inc_d   = 1'b1;
                        state_d = GAP;
                    end else begin
                        misses_d = miss_next;
                        state_d  = (miss_next == MISS_LIM) ? OVER : GAP;
                    end
                end else if (phase_done) begin
                    misses_d = miss_next;
                    state_d  = (miss_next == MISS_LIM) ? OVER : GAP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (state_d == SHOW) begin
            light_d = idx_to_onehot(idx_d);
        end else if (state_d == OVER) begin
            light_d = 3'b111;
            over_d  = 1'b1;
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            inc_q    <= 1'b0;
            light_q  <= 3'b000;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            inc_q    <= inc_d;
            light_q  <= light_d;
            over_q   <= over_d;
        end
    end

    assign gif.light     = light_q;
    assign gif.score     = score_q;
    assign gif.score_inc = inc_q;
    assign gif.misses    = misses_q;
    assign gif.game_over = over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with default parameters.
// Tracks the light-select LFSR independently to predict which light comes on.
module tb_game_round_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    game_round_ctrl_if gif ();

    game_round_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .gif   (gif)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    logic [1:0] last_idx;
    logic [5:0] exp_score;
    logic [1:0] exp_miss;

    // Reference LFSR: taps 8,6,5,4; m_prev holds the value seen by the latest edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic pulse_tick();
        gif.tick = 1'b1;
        @(negedge clk);
        gif.tick = 1'b0;
    endtask

    task automatic pulse_start();
        gif.start = 1'b1;
        @(negedge clk);
        gif.start = 1'b0;
    endtask

    task automatic press(input logic [2:0] b);
        gif.btn = b;
        @(negedge clk);
        gif.btn = 3'b000;
    endtask

    function automatic logic [2:0] oh(input logic [1:0] i);
        logic [2:0] one;
        one = 3'b001;
        return one << i;
    endfunction

    // Two GAP ticks; light must stay dark after the first and appear after the second
    task automatic enter_show(input string tag);
        logic [1:0] e;
        logic [2:0] el;
        pulse_tick();
        checks++;
        if (gif.light !== 3'b000) begin
            errors++;
            $display("FAIL %s gap_dark light=%b exp=000", tag, gif.light);
        end
        pulse_tick();
        if (m_prev[1:0] == 2'd3) e = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
        else e = m_prev[1:0];
        last_idx = e;
        el = oh(e);
        checks++;
        if (gif.light !== el) begin
            errors++;
            $display("FAIL %s show_light light=%b exp=%b", tag, gif.light, el);
        end
    endtask

    task automatic test_reset();
        gif.tick = 1'b0; gif.start = 1'b0; gif.btn = 3'b000;
        reset = 1'b0;
        last_idx = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gif.light, gif.score, gif.score_inc, gif.misses, gif.game_over} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {gif.light, gif.score, gif.score_inc, gif.misses, gif.game_over});
        end
        reset = 1'b1;
        @(negedge clk);
        press(3'b111);
        pulse_tick(); pulse_tick(); pulse_tick();
        press(3'b001);
        checks++;
        if ({gif.light, gif.score, gif.score_inc, gif.misses, gif.game_over} !== 13'd0) begin
            errors++;
            $display("FAIL idle_ignores_btn got=%h exp=0",
                     {gif.light, gif.score, gif.score_inc, gif.misses, gif.game_over});
        end
    endtask

    task automatic test_hit();
        pulse_start();
        checks++;
        if (gif.score !== 6'd0 || gif.misses !== 2'd0 || gif.light !== 3'b000 || gif.game_over !== 1'b0) begin
            errors++;
            $display("FAIL start_clear score=%0d misses=%0d light=%b over=%b exp 0/0/000/0",
                     gif.score, gif.misses, gif.light, gif.game_over);
        end
        enter_show("hit");
        press(oh(last_idx));
        checks++;
        if (gif.score_inc !== 1'b1 || gif.score !== 6'd1 || gif.light !== 3'b000) begin
            errors++;
            $display("FAIL hit inc=%b score=%0d light=%b exp 1/1/000", gif.score_inc, gif.score, gif.light);
        end
        @(negedge clk);
        checks++;
        if (gif.score_inc !== 1'b0) begin
            errors++;
            $display("FAIL hit_inc_pulse inc=%b exp=0", gif.score_inc);
        end
    endtask

    task automatic test_wrong();
        logic [1:0] other;
        enter_show("wrong");
        other = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
        press(oh(last_idx) | oh(other));
        checks++;
        if (gif.misses !== 2'd1 || gif.score !== 6'd1 || gif.score_inc !== 1'b0 ||
            gif.light !== 3'b000 || gif.game_over !== 1'b0) begin
            errors++;
            $display("FAIL wrong_press misses=%0d score=%0d inc=%b light=%b over=%b exp 1/1/0/000/0",
                     gif.misses, gif.score, gif.score_inc, gif.light, gif.game_over);
        end
    endtask

    task automatic test_press_on_timeout();
        enter_show("edge");
        repeat (7) pulse_tick();
        checks++;
        if (gif.light !== oh(last_idx)) begin
            errors++;
            $display("FAIL edge_still_lit light=%b exp=%b", gif.light, oh(last_idx));
        end
        gif.tick = 1'b1;
        gif.btn  = oh(last_idx);
        @(negedge clk);
        gif.tick = 1'b0;
        gif.btn  = 3'b000;
        checks++;
        if (gif.score !== 6'd2 || gif.score_inc !== 1'b1 || gif.misses !== 2'd1 || gif.light !== 3'b000) begin
            errors++;
            $display("FAIL press_on_timeout score=%0d inc=%b misses=%0d light=%b exp 2/1/1/000",
                     gif.score, gif.score_inc, gif.misses, gif.light);
        end
    endtask

    task automatic test_game_over();
        enter_show("over1");
        pulse_start();
        checks++;
        if (gif.light !== oh(last_idx) || gif.score !== 6'd2) begin
            errors++;
            $display("FAIL start_in_show light=%b score=%0d exp=%b/2", gif.light, gif.score, oh(last_idx));
        end
        repeat (7) pulse_tick();
        checks++;
        if (gif.misses !== 2'd1 || gif.light !== oh(last_idx)) begin
            errors++;
            $display("FAIL early_timeout misses=%0d light=%b exp 1/%b", gif.misses, gif.light, oh(last_idx));
        end
        pulse_tick();
        checks++;
        if (gif.misses !== 2'd2 || gif.light !== 3'b000 || gif.game_over !== 1'b0) begin
            errors++;
            $display("FAIL timeout2 misses=%0d light=%b over=%b exp 2/000/0", gif.misses, gif.light, gif.game_over);
        end
        enter_show("over2");
        repeat (8) pulse_tick();
        checks++;
        if (gif.misses !== 2'd3 || gif.light !== 3'b111 || gif.game_over !== 1'b1 || gif.score !== 6'd2) begin
            errors++;
            $display("FAIL game_over misses=%0d light=%b over=%b score=%0d exp 3/111/1/2",
                     gif.misses, gif.light, gif.game_over, gif.score);
        end
        press(3'b001);
        pulse_tick();
        checks++;
        if (gif.misses !== 2'd3 || gif.light !== 3'b111 || gif.game_over !== 1'b1 || gif.score !== 6'd2) begin
            errors++;
            $display("FAIL over_hold misses=%0d light=%b over=%b score=%0d exp 3/111/1/2",
                     gif.misses, gif.light, gif.game_over, gif.score);
        end
    endtask

    task automatic test_timeouts();
        pulse_start();
        checks++;
        if (gif.score !== 6'd0 || gif.misses !== 2'd0 || gif.light !== 3'b000 || gif.game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart score=%0d misses=%0d light=%b over=%b exp 0/0/000/0",
                     gif.score, gif.misses, gif.light, gif.game_over);
        end
        for (int i = 1; i <= 3; i++) begin
            enter_show("timeouts");
            repeat (8) pulse_tick();
            checks++;
            if (gif.misses !== 2'(i)) begin
                errors++;
                $display("FAIL timeout_count misses=%0d exp=%0d", gif.misses, i);
            end
        end
        checks++;
        if (gif.game_over !== 1'b1 || gif.light !== 3'b111 || gif.score !== 6'd0) begin
            errors++;
            $display("FAIL timeouts_over over=%b light=%b score=%0d exp 1/111/0", gif.game_over, gif.light, gif.score);
        end
    endtask

    task automatic test_saturation();
        int win;
        logic [2:0] exp_l;
        pulse_start();
        exp_score = 6'd0;
        exp_miss  = 2'd0;
        for (int i = 0; i < 64; i++) begin
`ifdef GAME_SPEEDUP_EN
            if (exp_score == 6'd16 || exp_score == 6'd48) begin
                win = (exp_score == 6'd16) ? 6 : 2;
                enter_show("speed");
                repeat (win - 1) pulse_tick();
                checks++;
                if (gif.light !== oh(last_idx)) begin
                    errors++;
                    $display("FAIL speed_lit score=%0d light=%b exp=%b", exp_score, gif.light, oh(last_idx));
                end
                pulse_tick();
                exp_miss = exp_miss + 2'd1;
                checks++;
                if (gif.misses !== exp_miss || gif.light !== 3'b000) begin
                    errors++;
                    $display("FAIL speed_window score=%0d misses=%0d light=%b exp %0d/000",
                             exp_score, gif.misses, gif.light, exp_miss);
                end
            end
`endif
            enter_show("sat");
            press(oh(last_idx));
            exp_score = (exp_score == 6'd63) ? 6'd63 : exp_score + 6'd1;
            checks++;
            if (gif.score !== exp_score || gif.score_inc !== 1'b1) begin
                errors++;
                $display("FAIL sat_hit score=%0d inc=%b exp %0d/1", gif.score, gif.score_inc, exp_score);
            end
        end
`ifdef GAME_SPEEDUP_EN
        win = 2;
`else
        win = 8;
`endif
        enter_show("floor");
        repeat (win - 1) pulse_tick();
        checks++;
        if (gif.light !== oh(last_idx)) begin
            errors++;
            $display("FAIL floor_lit light=%b exp=%b", gif.light, oh(last_idx));
        end
        pulse_tick();
        exp_miss = exp_miss + 2'd1;
        exp_l = (exp_miss == 2'd3) ? 3'b111 : 3'b000;
        checks++;
        if (gif.misses !== exp_miss || gif.light !== exp_l || gif.score !== 6'd63) begin
            errors++;
            $display("FAIL floor_window misses=%0d light=%b score=%0d exp %0d/%b/63",
                     gif.misses, gif.light, gif.score, exp_miss, exp_l);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_wrong();
        test_press_on_timeout();
        test_game_over();
        test_timeouts();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
